// File: rtl/count_stream_monitor_pkg.sv
// Shared types for the count stream monitor: FSM states, step classes and mode codes.
// Optional build macro COUNT_STREAM_MONITOR_TURN_CNT_EN is handled in the top module.
package count_mon_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StFirst,
    StAcq,
    StTrack
  } state_e;

  typedef enum logic [1:0] {
    StepUp,
    StepDown,
    StepHold,
    StepBad
  } step_e;

  localparam logic [1:0] ModeUnknown = 2'd0;
  localparam logic [1:0] ModeBounce  = 2'd1;
  localparam logic [1:0] ModeSweep   = 2'd2;

  // A wrap or a reversal away from the endpoints can only come from a free-running sweep.
  function automatic logic [1:0] next_mode(input logic [1:0] cur,
                                           input logic       wrap,
                                           input logic       rev,
                                           input logic       endpoint_rev);
    if (wrap || (rev && !endpoint_rev)) return ModeSweep;
    if (endpoint_rev && (cur == ModeUnknown)) return ModeBounce;
    return cur;
  endfunction

endpackage

// File: rtl/count_stream_monitor_if.sv
// Sample stream from the counter under observation into the monitor.
interface count_stream_monitor_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             sample_valid;
  logic [WIDTH-1:0] sample;

  modport master (
    output sample_valid,
    output sample
  );

  modport slave (
    input sample_valid,
    input sample
  );

endinterface

// File: rtl/count_step_classifier.sv
// Combinational classification of one observed step relative to the previous sample.
module count_step_classifier
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev_i,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             dir_i,
  output step_e            step_o,
  output logic             is_reversal_o,
  output logic             is_endpoint_rev_o,
  output logic             is_wrap_o
);

  localparam logic [WIDTH-1:0] Max = '1;

  logic [WIDTH-1:0] delta;
  logic             up;
  logic             down;

  // Modular difference makes the 15->0 / 0->15 wrap a normal single step.
  always_comb begin
    delta = sample_i - prev_i;
    if (delta == WIDTH'(1)) begin
      step_o = StepUp;
    end else if (delta == Max) begin
      step_o = StepDown;
    end else if (delta == '0) begin
      step_o = StepHold;
    end else begin
      step_o = StepBad;
    end
  end

  assign up   = (step_o == StepUp);
  assign down = (step_o == StepDown);

  assign is_reversal_o     = (up && dir_i) || (down && !dir_i);
  assign is_endpoint_rev_o = ((prev_i == Max) && down && !dir_i) ||
                             ((prev_i == '0) && up && dir_i);
  assign is_wrap_o         = ((prev_i == Max) && up) || ((prev_i == '0) && down);

endmodule

// File: rtl/count_stream_monitor.sv
// Receiver-side monitor for the up/down counter stream: lock, direction, mode and step errors.
// Build macro COUNT_STREAM_MONITOR_TURN_CNT_EN adds a saturating turn_count output.
module count_stream_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_STEPS = 2,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 Reset,
  count_stream_monitor_if.slave in_if,
  output logic                 locked,
  output logic                 dir,
  output logic [1:0]           mode,
  output logic                 turn,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef COUNT_STREAM_MONITOR_TURN_CNT_EN
  ,
  output logic [7:0]           turn_count
`endif
);

  localparam int unsigned GoodW = $clog2(LOCK_STEPS + 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [GoodW-1:0]     good_q, good_d;
  logic                 locked_q, locked_d;
  logic                 dir_q, dir_d;
  logic [1:0]           mode_q, mode_d;
  logic                 turn_q, turn_d;
  logic                 step_err_q, step_err_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  step_e step;
  logic  is_rev;
  logic  is_ep_rev;
  logic  is_wrap;
  logic  legal;
  logic  bad;
  logic  acq_done;

  count_step_classifier #(
    .WIDTH (WIDTH)
  ) u_classifier (
    .prev_i            (prev_q),
    .sample_i          (in_if.sample),
    .dir_i             (dir_q),
    .step_o            (step),
    .is_reversal_o     (is_rev),
    .is_endpoint_rev_o (is_ep_rev),
    .is_wrap_o         (is_wrap)
  );

  assign legal    = (step == StepUp) || (step == StepDown);
  assign bad      = (step == StepBad);
  assign acq_done = ((good_q + GoodW'(1)) == GoodW'(LOCK_STEPS));

  always_ff @(posedge clk) begin : state_reg
    if (Reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    if (in_if.sample_valid) begin
      unique case (state_q)
        StEmpty: state_d = StFirst;
        StFirst: begin
          if (legal) state_d = (LOCK_STEPS == 1) ? StTrack : StAcq;
        end
        StAcq: begin
          if (legal && acq_done) begin
            state_d = StTrack;
          end else if (bad) begin
            state_d = StFirst;
          end
        end
        StTrack: begin
          if (bad) state_d = StFirst;
        end
      endcase
    end
  end

  always_comb begin : outputs
    prev_d     = prev_q;
    good_d     = good_q;
    dir_d      = dir_q;
    mode_d     = mode_q;
    turn_d     = 1'b0;
    step_err_d = 1'b0;
    err_d      = err_q;
    if (in_if.sample_valid) begin
      prev_d = in_if.sample;
      unique case (state_q)
        StEmpty: ;
        StFirst: begin
          if (legal) begin
            dir_d  = (step == StepDown);
            good_d = GoodW'(1);
          end
        end
        StAcq: begin
          if (legal) begin
            dir_d  = (step == StepDown);
            good_d = good_q + GoodW'(1);
            mode_d = next_mode(mode_q, is_wrap, is_rev, is_ep_rev);
          end else if (bad) begin
            good_d = '0;
            mode_d = ModeUnknown;
          end
        end
        StTrack: begin
          if (legal) begin
            dir_d  = (step == StepDown);
            mode_d = next_mode(mode_q, is_wrap, is_rev, is_ep_rev);
            turn_d = is_rev;
          end else if (bad) begin
            step_err_d = 1'b1;
            err_d      = (err_q == '1) ? err_q : err_q + ERR_CNT_W'(1);
            good_d     = '0;
            mode_d     = ModeUnknown;
          end
        end
      endcase
    end
    locked_d = (state_d == StTrack);
  end

  always_ff @(posedge clk) begin : data_reg
    if (Reset) begin
      prev_q     <= '0;
      good_q     <= '0;
      locked_q   <= 1'b0;
      dir_q      <= 1'b0;
      mode_q     <= ModeUnknown;
      turn_q     <= 1'b0;
      step_err_q <= 1'b0;
      err_q      <= '0;
    end else begin
      prev_q     <= prev_d;
      good_q     <= good_d;
      locked_q   <= locked_d;
      dir_q      <= dir_d;
      mode_q     <= mode_d;
      turn_q     <= turn_d;
      step_err_q <= step_err_d;
      err_q      <= err_d;
    end
  end

  assign locked    = locked_q;
  assign dir       = dir_q;
  assign mode      = mode_q;
  assign turn      = turn_q;
  assign step_err  = step_err_q;
  assign err_count = err_q;

`ifdef COUNT_STREAM_MONITOR_TURN_CNT_EN
  logic [7:0] turn_cnt_q, turn_cnt_d;

  always_comb begin
    turn_cnt_d = turn_cnt_q;
    if (turn_d && (turn_cnt_q != 8'hff)) turn_cnt_d = turn_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      turn_cnt_q <= '0;
    end else begin
      turn_cnt_q <= turn_cnt_d;
    end
  end

  assign turn_count = turn_cnt_q;
`endif

endmodule

// File: tb/tb_count_stream_monitor.sv
// Directed and randomized checks of count_stream_monitor against a step-counting reference model.
module tb_count_stream_monitor;

  localparam int unsigned W = 4;
  localparam int unsigned L = 2;
  localparam int unsigned E = 8;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  count_stream_monitor_if #(.WIDTH(W)) bus_if ();

  logic         locked;
  logic         dir;
  logic [1:0]   mode;
  logic         turn;
  logic         step_err;
  logic [E-1:0] err_count;
`ifdef COUNT_STREAM_MONITOR_TURN_CNT_EN
  logic [7:0]   turn_count;
`endif

  count_stream_monitor #(
    .WIDTH      (W),
    .LOCK_STEPS (L),
    .ERR_CNT_W  (E)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .in_if      (bus_if),
    .locked     (locked),
    .dir        (dir),
    .mode       (mode),
    .turn       (turn),
    .step_err   (step_err),
    .err_count  (err_count)
`ifdef COUNT_STREAM_MONITOR_TURN_CNT_EN
    ,
    .turn_count (turn_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: counts consecutive legal steps since the last anchor sample.
  bit m_seen;
  int m_run;
  int m_prev;
  bit m_dir;
  int m_mode;
  int m_err;
  int m_tc;
  bit m_turn;
  bit m_serr;

  function automatic void model_reset();
    m_seen = 0; m_run = 0; m_prev = 0; m_dir = 0; m_mode = 0;
    m_err = 0; m_tc = 0; m_turn = 0; m_serr = 0;
  endfunction

  function automatic void model_step(input bit rst, input bit v, input int s);
    int d;
    bit up, rev, top, bot;
    m_turn = 0;
    m_serr = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (!v) return;
    if (!m_seen) begin
      m_seen = 1;
      m_prev = s;
      return;
    end
    d = (s - m_prev + 16) % 16;
    if (d == 1 || d == 15) begin
      up = (d == 1);
      if (m_run == 0) begin
        m_run = 1;
      end else begin
        rev = (m_dir == up);
        top = (m_prev == 15);
        bot = (m_prev == 0);
        if ((top && up) || (bot && !up)) m_mode = 2;
        else if (rev && ((top && !up) || (bot && up))) begin
          if (m_mode == 0) m_mode = 1;
        end else if (rev) m_mode = 2;
        if (rev && m_run >= L) begin
          m_turn = 1;
          if (m_tc < 255) m_tc++;
        end
        m_run++;
      end
      m_dir = !up;
    end else if (d != 0) begin
      if (m_run >= L) begin
        m_serr = 1;
        if (m_err < 255) m_err++;
      end
      if (m_run > 0) m_mode = 0;
      m_run = 0;
    end
    m_prev = s;
  endfunction

  task automatic drive(input logic rst, input logic v, input logic [W-1:0] s);
    @(negedge clk);
    Reset               = rst;
    bus_if.sample_valid = v;
    bus_if.sample       = s;
    @(posedge clk);
    #1;
    Reset               = 1'b0;
    bus_if.sample_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] s);
    drive(1'b0, 1'b1, s);
  endtask

  function automatic logic [13:0] obs();
    return {locked, dir, mode, turn, step_err, err_count};
  endfunction

  task automatic test_reset();
    drive(1'b1, 1'b0, 4'd0);
    checks++;
    if (obs() !== 14'd0) begin
      errors++;
      $display("FAIL reset_state got %h want %h", obs(), 14'd0);
    end
  endtask

  task automatic test_lockup();
    logic [13:0] exp;
    drive(1'b1, 1'b0, 4'd0);
    send(4'd0);
    send(4'd1);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_after_1 got %b want 0", locked);
    end
    send(4'd2);
    exp = {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL lock_after_2 got %h want %h", obs(), exp);
    end
    send(4'd3);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL lock_after_3 got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_bounce();
    logic [13:0] exp;
    drive(1'b1, 1'b0, 4'd0);
    send(4'd11); send(4'd12); send(4'd13); send(4'd14); send(4'd15);
    exp = {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL bounce_at_15 got %h want %h", obs(), exp);
    end
    drive(1'b0, 1'b0, 4'd3);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL bounce_idle got %h want %h", obs(), exp);
    end
    send(4'd14);
    exp = {1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 8'd0};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL bounce_turn got %h want %h", obs(), exp);
    end
    send(4'd13);
    exp = {1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL bounce_after got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_sweep_wrap();
    logic [13:0] exp;
    drive(1'b1, 1'b0, 4'd0);
    send(4'd12); send(4'd13); send(4'd14); send(4'd15);
    send(4'd0);
    exp = {1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 8'd0};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL wrap_to_0 got %h want %h", obs(), exp);
    end
    send(4'd1);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL wrap_after got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_illegal();
    logic [13:0] exp;
    drive(1'b1, 1'b0, 4'd0);
    send(4'd3); send(4'd4); send(4'd5);
    send(4'd9);
    exp = {1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'd1};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL illegal_9 got %h want %h", obs(), exp);
    end
    send(4'd10);
    exp = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd1};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL illegal_10 got %h want %h", obs(), exp);
    end
    send(4'd11);
    exp = {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd1};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL relock_11 got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_midrange();
    logic [13:0] exp;
    drive(1'b1, 1'b0, 4'd0);
    send(4'd3); send(4'd4); send(4'd5); send(4'd6); send(4'd7);
    send(4'd6);
    exp = {1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 8'd0};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL mid_turn got %h want %h", obs(), exp);
    end
`ifdef COUNT_STREAM_MONITOR_TURN_CNT_EN
    checks++;
    if (turn_count !== 8'd1) begin
      errors++;
      $display("FAIL mid_turn_count got %0d want 1", turn_count);
    end
`endif
    drive(1'b0, 1'b0, 4'd0);
    exp = {1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 8'd0};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL mid_idle got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_reset_collision();
    logic [13:0] exp;
    drive(1'b1, 1'b0, 4'd0);
    send(4'd0); send(4'd1); send(4'd2); send(4'd9);
    drive(1'b1, 1'b1, 4'd7);
    checks++;
    if (obs() !== 14'd0) begin
      errors++;
      $display("FAIL collision got %h want %h", obs(), 14'd0);
    end
    send(4'd8);
    checks++;
    if (obs() !== 14'd0) begin
      errors++;
      $display("FAIL collision_8 got %h want %h", obs(), 14'd0);
    end
    send(4'd9);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL collision_9 got locked=%b want 0", locked);
    end
    send(4'd10);
    exp = {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL collision_10 got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_err_saturation();
    logic [W-1:0] p;
    drive(1'b1, 1'b0, 4'd0);
    p = 4'd0;
    send(p);
    for (int i = 0; i < 260; i++) begin
      send(p + 4'd1);
      send(p + 4'd2);
      p = p + 4'd7;
      send(p);
      if (i == 99) begin
        checks++;
        if (err_count !== 8'd100) begin
          errors++;
          $display("FAIL err_count_100 got %0d want 100", err_count);
        end
      end
    end
    checks++;
    if (err_count !== 8'hff || step_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sat got cnt=%0d pulse=%b want 255 1", err_count, step_err);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] last, s;
    logic [13:0]  exp;
    bit           rst, v;
    int           r;
    drive(1'b1, 1'b0, 4'd0);
    model_reset();
    last = 4'd0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      v   = ($urandom_range(0, 99) < 80);
      r   = $urandom_range(0, 99);
      if (r < 40) s = last + 4'd1;
      else if (r < 70) s = last - 4'd1;
      else if (r < 82) s = last;
      else s = 4'($urandom_range(0, 15));
      if (v) last = s;
      drive(rst, v, s);
      model_step(rst, v, int'(s));
      exp = {(m_run >= L), m_dir, 2'(m_mode), m_turn, m_serr, 8'(m_err)};
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL random_%0d got %h want %h", i, obs(), exp);
      end
`ifdef COUNT_STREAM_MONITOR_TURN_CNT_EN
      checks++;
      if (turn_count !== 8'(m_tc)) begin
        errors++;
        $display("FAIL random_tc_%0d got %0d want %0d", i, turn_count, m_tc);
      end
`endif
    end
  endtask

  initial begin
    Reset               = 1'b1;
    bus_if.sample_valid = 1'b0;
    bus_if.sample       = '0;
    test_reset();
    test_lockup();
    test_bounce();
    test_sweep_wrap();
    test_illegal();
    test_midrange();
    test_reset_collision();
    test_err_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_stream_monitor.md
Name: count_stream_monitor

Overview:
- Receiver-side checker for the 4-bit auto/manual up-down counter stream; sits downstream of the counter on the board.
- Recovers count direction and operating mode (bounce vs sweep), detects reversals, and flags illegal steps with a saturating error count.
- Samples on the rising edge of clk, mid-cycle of a negedge-updated source.

Parameters:
- WIDTH, 4, sample width; MAX = 2^WIDTH-1.
- LOCK_STEPS, 2, consecutive legal steps required to lock (>=1).
- ERR_CNT_W, 8, width of err_count.

Ports:
- clk  in  1  clock; all logic rising-edge.
- Reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  sample is taken on this edge.
- sample  in  WIDTH  observed counter value.
- locked  out  1  monitor is in TRACK.
- dir  out  1  last legal step direction: 0 up, 1 down.
- mode  out  2  0 UNKNOWN, 1 BOUNCE, 2 SWEEP.
- turn  out  1  one-cycle pulse on a direction reversal while locked.
- step_err  out  1  one-cycle pulse on an illegal step while locked.
- err_count  out  ERR_CNT_W  saturating count of step_err events.

Behaviour:
- Reset (sync, wins over sample_valid on the same edge): state=EMPTY, prev=0, good_cnt=0, all outputs 0, mode=UNKNOWN.
- All outputs are registered. They reflect a sample immediately after the edge that takes it (1-cycle latency). Edges with sample_valid=0 change nothing; turn and step_err drop to 0.
- Step class uses delta = (sample - prev) mod 2^WIDTH:
  - 1 = UP.
  - MAX = DOWN.
  - 0 = HOLD.
  - anything else = BAD.
- HOLD never changes state, dir, or mode.
- prev <= sample on every valid sample.
- FSM:
  - EMPTY: on valid sample -> FIRST.
  - FIRST: UP/DOWN -> set dir, good_cnt=1, go to ACQ (or TRACK if LOCK_STEPS==1). BAD -> stay, no error.
  - ACQ: UP/DOWN -> good_cnt++, update dir, go to TRACK when good_cnt reaches LOCK_STEPS. BAD -> FIRST, good_cnt=0, mode=UNKNOWN, no error.
  - TRACK: UP/DOWN -> update dir. BAD -> step_err=1, err_count++ (saturates at all-ones), mode=UNKNOWN, good_cnt=0, go to FIRST.
- Reversal: step direction differs from current dir (ACQ or TRACK). turn pulses only in TRACK.
- Mode rules (ACQ and TRACK):
  - Endpoint reversal sets BOUNCE if mode is UNKNOWN. Endpoint reversal means prev==MAX with DOWN after up, or prev==0 with UP after down.
  - A wrap sets SWEEP. Wrap means prev==MAX with UP, or prev==0 with DOWN.
  - A mid-range reversal sets SWEEP.
  - SWEEP is sticky until Reset or loss of lock.
- Wrap is a legal step (UP 15->0, DOWN 0->15 for WIDTH=4).
- Reset mid-stream: the next valid sample restarts from EMPTY; err_count is cleared.

Optional Feature:
- Macro COUNT_STREAM_MONITOR_TURN_CNT_EN.
- Defined: adds output turn_count[7:0], reset 0, incremented on every turn pulse, saturating at 255.
- Undefined: port and logic absent; all other behaviour is identical.

Decomposition:
- Package count_mon_pkg holds:
  - state enum (EMPTY, FIRST, ACQ, TRACK);
  - step class enum (UP, DOWN, HOLD, BAD);
  - mode encoding constants (UNKNOWN=0, BOUNCE=1, SWEEP=2).
- One sub-module: count_step_classifier. It is combinational; inputs are prev, sample and dir. It outputs step class, is_reversal, is_endpoint_rev and is_wrap.

Test Plan:
1. Lock-up: after Reset, valid samples 0,1,2,3 -> locked=1 after the edge taking 2; dir=0; mode=UNKNOWN; no pulses.
2. Bounce: locked feed 13,14,15,14,13 -> turn=1 for exactly the cycle after taking the second 14; dir=1; mode=BOUNCE; err_count=0.
3. Sweep wrap: locked feed 14,15,0,1 -> mode=SWEEP after taking 0; dir=0; no turn; no step_err.
4. Illegal step: locked at 5, feed 9 -> step_err one cycle, err_count=1, locked=0, mode=UNKNOWN. Then 10,11 -> relocked after taking 11.
5. Mid-range reversal: locked feed 5,6,7,6 -> turn pulse, dir=1, mode=SWEEP. With COUNT_STREAM_MONITOR_TURN_CNT_EN, turn_count=1.
6. Reset collision: Reset=1 with sample_valid=1, sample=7 on the same edge -> all outputs 0, state EMPTY. The next sample 8 does not lock; it only moves the FSM to FIRST.
